// File: rtl/pwm_mch_pkg.sv
// pwm_mch shared constants: control bits, address offsets, write edge pattern.
// Optional centre-aligned mode is compiled in with PWM_MCH_CENTER_EN.
package pwm_mch_pkg;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_CENTER_BIT = 1;

  localparam int ADDR_PERIOD_OFS = 0;
  localparam int ADDR_CTRL_OFS   = 1;

  localparam logic [1:0] WR_EDGE_PAT = 2'b01;

endpackage

// File: rtl/pwm_mch_ch.sv
// pwm_mch channel: duty shadow/active pair, comparator and output flop.
// Centre-mode compare inputs are tied low unless PWM_MCH_CENTER_EN is set.
module pwm_mch_ch
  import pwm_mch_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DUTY_RST = 0
) (
  input  logic             refClock,
  input  logic             rst,
  input  logic             wrDuty,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] periodAct,
  input  logic             ctrUp,
  input  logic             ctrDown,
  output logic             pwm,
  output logic             pending
);

  localparam logic [WIDTH-1:0] DUTY_INIT = WIDTH'(DUTY_RST);

  logic [WIDTH-1:0] dutySh;
  logic [WIDTH-1:0] dutyAct;
  logic [WIDTH:0]   sum;
  logic             hit;

  always_ff @(posedge refClock or posedge rst) begin
    if (rst) begin
      dutySh  <= DUTY_INIT;
      dutyAct <= DUTY_INIT;
    end else begin
      if (wrDuty) dutySh <= data;
      if (load)   dutyAct <= dutySh;
    end
  end

  // centre mode: high while the distance to the peak is below duty
  always_comb begin
    sum = {1'b0, cnt} + {1'b0, dutyAct};
    hit = 1'b0;
    unique case (1'b1)
      ctrUp:   hit = sum >  {1'b0, periodAct};
      ctrDown: hit = sum >= {1'b0, periodAct};
      default: hit = cnt < dutyAct;
    endcase
  end

  always_ff @(posedge refClock or posedge rst) begin
    if (rst) pwm <= 1'b0;
    else     pwm <= en && hit;
  end

  assign pending = dutySh != dutyAct;

endmodule

// File: rtl/pwm_mch.sv
// pwm_mch top: write decode, control, shared period counter, CH channels.
// Define PWM_MCH_CENTER_EN to make the CENTER control bit functional.
module pwm_mch
  import pwm_mch_pkg::*;
#(
  parameter int CH         = 4,
  parameter int WIDTH      = 16,
  parameter int PERIOD_RST = 124,
  parameter int DUTY_RST   = 0,
  parameter int ADDR_W     = $clog2(CH + 2)
) (
  input  logic              refClock,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  data,
  output logic [CH-1:0]     outPwm,
  output logic              outEventCnt,
  output logic              updPending
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] PER_INIT = WIDTH'(PERIOD_RST);

  logic [1:0]       wrSr;
  logic             wrStbQ;
  logic             wrPeriod;
  logic             wrCtrl;
  logic             en;
  logic             center;
  logic [WIDTH-1:0] periodSh;
  logic [WIDTH-1:0] periodAct;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cntNext;
  logic             load;
  logic             ctrUp;
  logic             ctrDown;
  logic [CH-1:0]    chPend;

  // strobe is registered once so the shadow lands two edges after wrEn rises
  always_ff @(posedge refClock or posedge rst) begin
    if (rst) begin
      wrSr   <= 2'b00;
      wrStbQ <= 1'b0;
    end else begin
      wrSr   <= {wrSr[0], wrEn};
      wrStbQ <= wrSr == WR_EDGE_PAT;
    end
  end

  assign wrPeriod = wrStbQ && int'(wrAddr) == CH + ADDR_PERIOD_OFS;
  assign wrCtrl   = wrStbQ && int'(wrAddr) == CH + ADDR_CTRL_OFS;

  always_ff @(posedge refClock or posedge rst) begin
    if (rst) begin
      en        <= 1'b1;
      center    <= 1'b0;
      periodSh  <= PER_INIT;
      periodAct <= PER_INIT;
    end else begin
      if (wrCtrl) begin
        en     <= data[CTRL_EN_BIT];
        center <= data[CTRL_CENTER_BIT];
      end
      if (wrPeriod) periodSh <= data;
      if (load)     periodAct <= periodSh;
    end
  end

`ifdef PWM_MCH_CENTER_EN
  logic dirUp;
  logic dirNext;

  always_ff @(posedge refClock or posedge rst) begin
    if (rst) dirUp <= 1'b1;
    else     dirUp <= dirNext;
  end
`else
  logic unusedCenter;
  assign unusedCenter = center;
`endif

  always_comb begin
    cntNext = cnt;
    load    = 1'b0;
    ctrUp   = 1'b0;
    ctrDown = 1'b0;
`ifdef PWM_MCH_CENTER_EN
    dirNext = dirUp;
`endif
    if (!en) begin
      cntNext = '0;
      load    = 1'b1;
`ifdef PWM_MCH_CENTER_EN
      dirNext = 1'b1;
`endif
    end
`ifdef PWM_MCH_CENTER_EN
    else if (center && periodAct != '0) begin
      ctrUp   = dirUp || cnt == '0;
      ctrDown = !ctrUp;
      if (cnt == '0) begin
        cntNext = ONE;
        load    = 1'b1;
        dirNext = 1'b1;
      end else if (dirUp && cnt >= periodAct) begin
        cntNext = cnt - ONE;
        dirNext = 1'b0;
      end else if (dirUp) begin
        cntNext = cnt + ONE;
      end else begin
        cntNext = cnt - ONE;
      end
    end
`endif
    else if (cnt >= periodAct) begin
      cntNext = '0;
      load    = 1'b1;
`ifdef PWM_MCH_CENTER_EN
      dirNext = 1'b1;
`endif
    end else begin
      cntNext = cnt + ONE;
    end
  end

  always_ff @(posedge refClock or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      outEventCnt <= 1'b0;
    end else begin
      cnt         <= cntNext;
      outEventCnt <= en && cnt == '0;
    end
  end

  for (genvar n = 0; n < CH; n++) begin : gCh
    pwm_mch_ch #(
      .WIDTH    (WIDTH),
      .DUTY_RST (DUTY_RST)
    ) uCh (
      .refClock  (refClock),
      .rst       (rst),
      .wrDuty    (wrStbQ && int'(wrAddr) == n),
      .data      (data),
      .load      (load),
      .en        (en),
      .cnt       (cnt),
      .periodAct (periodAct),
      .ctrUp     (ctrUp),
      .ctrDown   (ctrDown),
      .pwm       (outPwm[n]),
      .pending   (chPend[n])
    );
  end

  assign updPending = (periodSh != periodAct) || (|chPend);

endmodule

// File: tb/tb_pwm_mch.sv
// pwm_mch bench: directed steps then random register writes,
// checked every cycle against a period/position reference model.
module tb_pwm_mch;

  localparam int CH = 4;
  localparam int W  = 16;

  logic          refClock = 1'b0;
  logic          rst;
  logic          wrEn;
  logic [2:0]    wrAddr;
  logic [W-1:0]  data;
  logic [CH-1:0] outPwm;
  logic          outEventCnt;
  logic          updPending;

  pwm_mch #(
    .CH         (CH),
    .WIDTH      (W),
    .PERIOD_RST (124),
    .DUTY_RST   (0)
  ) dut (
    .refClock    (refClock),
    .rst         (rst),
    .wrEn        (wrEn),
    .wrAddr      (wrAddr),
    .data        (data),
    .outPwm      (outPwm),
    .outEventCnt (outEventCnt),
    .updPending  (updPending)
  );

  always #5 refClock = ~refClock;

  int nCmp = 0;
  int nBad = 0;

  // reference: settings in force, pending settings, position in period
  int mPos;
  int mPer;
  int mDuty [CH];
  int sPer;
  int sDuty [CH];
  bit mEn;
  int edgeNum;
  int wrAt;
  int wrA;
  int wrD;
  int evtSeen;
  logic [CH-1:0] eP;
  logic          eE;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nCmp++;
    assert (got === exp) else begin
      nBad++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mPos = 0;
    mPer = 124;
    sPer = 124;
    mEn  = 1'b1;
    for (int n = 0; n < CH; n++) begin
      mDuty[n] = 0;
      sDuty[n] = 0;
    end
    wrAt    = -1;
    edgeNum = 0;
  endtask

  function automatic bit expPending();
    bit p;
    p = sPer != mPer;
    for (int n = 0; n < CH; n++)
      if (sDuty[n] != mDuty[n]) p = 1'b1;
    return p;
  endfunction

  task automatic modelEdge();
    edgeNum++;
    for (int n = 0; n < CH; n++)
      eP[n] = mEn && (mPos < mDuty[n]);
    eE = mEn && mPos == 0;
    // a period ends after mPer+1 positions; new settings start with it
    if (!mEn || mPos == mPer) begin
      mPos = 0;
      mPer = sPer;
      for (int n = 0; n < CH; n++) mDuty[n] = sDuty[n];
    end else begin
      mPos++;
    end
    if (edgeNum == wrAt) begin
      if (wrA < CH)          sDuty[wrA] = wrD;
      else if (wrA == CH)    sPer = wrD;
      else if (wrA == CH + 1) mEn = wrD[0];
    end
  endtask

  task automatic cycle();
    @(posedge refClock);
    modelEdge();
    @(negedge refClock);
    if (outEventCnt === 1'b1) evtSeen++;
    check("pwm", 32'(outPwm), 32'(eP));
    check("evt", 32'(outEventCnt), 32'(eE));
    check("pend", 32'(updPending), 32'(expPending()));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(int a, int d);
    wrEn   = 1'b1;
    wrAddr = a[2:0];
    data   = d[W-1:0];
    wrA    = a;
    wrD    = d;
    wrAt   = edgeNum + 3;
    run(3);
    wrEn   = 1'b0;
    wrAddr = 3'($urandom);
    data   = W'($urandom);
    cycle();
  endtask

  task automatic asyncReset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_pwm", 32'(outPwm), 32'(0));
    check("rst_evt", 32'(outEventCnt), 32'(0));
    check("rst_pend", 32'(updPending), 32'(0));
    @(negedge refClock);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    bit hit;
    int a;
    int d;
    rst    = 1'b1;
    wrEn   = 1'b0;
    wrAddr = '0;
    data   = '0;
    #12;
    check("init_pwm", 32'(outPwm), 32'(0));
    check("init_evt", 32'(outEventCnt), 32'(0));
    check("init_pend", 32'(updPending), 32'(0));
    @(negedge refClock);
    rst = 1'b0;
    modelReset();

    evtSeen = 0;
    run(250);
    check("evt_count_250", 32'(evtSeen), 32'(2));

    run(37);
    wr(1, 50);
    run(260);

    wr(CH, 9);
    wr(0, 0);
    wr(1, 10);
    wr(2, 9);
    run(40);

    wr(CH + 1, 0);
    run(5);
    wr(CH + 1, 1);
    run(20);

    // align a duty write with the load edge
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (mEn && mPos + 2 == mPer) hit = 1'b1;
      else cycle();
    end
    check("loadpt_sync", 32'(hit), 32'(1));
    wr(3, 5);
    run(25);

    wr(CH, 0);
    evtSeen = 0;
    run(10);
    check("evt_count_p0", 32'(evtSeen), 32'(10));

    wr(CH + 1, 1);
    for (int k = 0; k < 200; k++) begin
      a = int'($urandom_range(0, 7));
      if (a == CH)          d = int'($urandom_range(0, 20));
      else if (a == CH + 1) d = ($urandom_range(0, 7) == 0) ? 2 : 1;
      else                  d = int'($urandom_range(0, 24));
      if (a == CH + 1 && $urandom_range(0, 1) == 1) d = d | 2;
      wr(a, d);
      run(int'($urandom_range(0, 15)));
    end

    asyncReset();
    run(30);
    wr(2, 60);
    run(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/pwm_mch.md
# pwm_mch

Parametrised multi-channel PWM generator; successor to the single-channel 800 kHz-referenced PWM. One shared period counter drives CH comparators with double-buffered (shadowed) period and duty registers, so updates take effect only at period boundaries and never glitch an output. It sits between the host write port (register strobe plus data bus) and the power-stage/LED drive pins.

## Interface
- CH, 4, number of PWM channels (1..16)
- WIDTH, 16, counter/period/duty width in bits
- PERIOD_RST, 124, period value after reset
- DUTY_RST, 0, duty value of every channel after reset
- ADDR_W, $clog2(CH+2), write address width (derived, do not override)

- refClock  in  1  reference clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wrEn  in  1  write request, level; one write per rising edge, edge-detected internally
- wrAddr  in  ADDR_W  0..CH-1 duty of channel n; CH period; CH+1 control
- data  in  WIDTH  write data
- outPwm  out  CH  PWM outputs, registered
- outEventCnt  out  1  one-cycle pulse at each period start, registered
- updPending  out  1  high while any shadow register differs from its active copy

## Operation
- Write port: wrEn sampled into a 2-flop shift register; pattern 01 = one write strobe. wrAddr/data sampled on the strobe cycle; held stable by the host for 3 cycles from wrEn rise. Addresses > CH+1 ignored.
- Control register: bit0 EN (reset 1), bit1 CENTER (reset 0; ignored unless macro compiled in), other bits read as 0/ignored.
- Shadow regs: periodSh, dutySh[n], written by strobes. Active regs periodAct, dutyAct[n] loaded from shadows at the load point. Strobe and load in same cycle: load takes pre-write shadow; new value applies one period later.
- Edge mode: cnt counts 0..periodAct, then wraps to 0. Load point = cycle cnt==periodAct.
- Compare: outPwm[n] <= EN && (cnt < dutyAct[n]). Duty 0 -> constantly low; duty > periodAct -> constantly high; duty == periodAct -> low for exactly one cycle per period.
- EN=0: cnt held at 0, outPwm all 0, outEventCnt 0, active regs load from shadows every cycle. EN 0->1: counting starts at 0 with current shadows.
- periodAct=0: cnt stays 0, outEventCnt high every cycle, outPwm[n]=(dutyAct[n]!=0).
- Arithmetic: all unsigned WIDTH bits; cnt never exceeds periodAct, no overflow path.

## Timing
- Reset: cnt=0, outPwm=0, outEventCnt=0, updPending=0, periodSh/Act=PERIOD_RST, dutySh/Act=DUTY_RST, EN=1, CENTER=0.
- wrEn rises before edge k -> shadow updated at edge k+2.
- Compare latency 1 cycle: outPwm and outEventCnt reflect cnt of previous cycle; outEventCnt and outPwm rise on the same edge.
- Edge-mode period = periodAct+1 cycles; high time = min(dutyAct, periodAct+1) cycles.
- Reset asserted mid-period: all outputs low immediately (async); restart from cnt=0 on first edge after release.

## Configuration
- PWM_MCH_CENTER_EN defined: CENTER bit functional. CENTER=1: cnt counts up 0..periodAct then down to 1 (period = 2*periodAct cycles, periodAct=0 behaves as edge mode); load point = cnt==0 with direction down->up; outEventCnt pulses at cnt==0 only; outputs symmetric about cnt==periodAct.
- Not defined: CENTER bit stored but ignored, up/down logic and direction flop not synthesised; edge mode only.

## Structure
- Package pwm_mch_pkg: control bit positions (CTRL_EN_BIT, CTRL_CENTER_BIT), address offsets (ADDR_PERIOD_OFS=0 relative to CH, ADDR_CTRL_OFS=1), edge-detect pattern constant.
- One sub-module natural: pwm_mch_ch (per-channel duty shadow, active reg, comparator, output flop), instantiated CH times via generate; counter, write decode and control live in the top.

## Test plan
- Reset, no writes: period 125 cycles, outEventCnt every 125 cycles, all outPwm low (DUTY_RST=0).
- Write duty ch1=50 mid-period -> old duty to end of period; from next outEventCnt ch1 high 50 of 125 cycles; updPending high until load.
- Write period=9, duty ch0=0, ch1=10, ch2=9 -> ch0 always low, ch1 always high, ch2 high 9 low 1 per 10-cycle period.
- Write ctrl EN=0 during high phase -> outputs low next cycle, cnt=0; EN=1 -> outEventCnt pulse first cycle after restart.
- Strobe landing on load-point cycle -> new duty applied one period later; period=0 -> outEventCnt constant high.
- PWM_MCH_CENTER_EN, CENTER=1, period=8, duty=4 -> 16-cycle period, output high 8 cycles centred on cnt==8.
